// File: rtl/montgomery_redc_serial.sv
// Purpose : radix-2 bit-serial Montgomery reduction, y = a * 2^(-k) mod m, one bit per clock.
// Latency : start sampled at E0 -> y and done_irq_p valid after E(k+1); done_irq_p is one cycle wide.
// Backpres: none; enable_p is ignored while busy, a new start is taken in the done_irq_p cycle.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   enable_p     - start strobe (accepted only when idle)
//   a            - Montgomery-domain operand, expected a < 2*m
//   m            - odd modulus, m > 1
//   m_size       - exponent k (R = 2^k), clamped to NBITS
//   y            - registered result, held until the next completion
//   done_irq_p   - registered one-cycle completion pulse
//   busy         - high while an operation is in progress
module montgomery_redc_serial #(
  parameter int NBITS = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] m,
  input  logic [10:0]      m_size,
  output logic [NBITS-1:0] y,
  output logic             done_irq_p,
  output logic             busy
);

  // One bit wider than m_size so that k = NBITS (up to 2048) is representable.
  localparam int KW = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [NBITS:0]   t_q;
  logic [NBITS-1:0] m_q;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    cnt_q;

  logic [KW-1:0]    k_eff;
  logic [NBITS:0]   t_add;
  logic [NBITS:0]   t_iter;
  logic [NBITS-1:0] t_sub;
  logic             t_ge_m;
  logic [NBITS-1:0] y_nxt;

  // Effective exponent: min(m_size, NBITS).
  always_comb begin
    k_eff = {1'b0, m_size};
    if ({1'b0, m_size} > KW'(NBITS)) begin
      k_eff = KW'(NBITS);
    end
  end

  // (T + m) >> 1 computed without a wider adder:
  //   (T >> 1) + (m >> 1) + (T[0] & m[0]).
  // Only used when T[0] = 1, so the carry-in is just m[0]. With T < 2^(NBITS+1)
  // and m < 2^NBITS the result stays below 2^(NBITS+1), so nothing is lost.
  always_comb begin
    t_add  = {1'b0, t_q[NBITS:1]} + (NBITS+1)'(m_q[NBITS-1:1]) + (NBITS+1)'(m_q[0]);
    t_iter = t_q[0] ? t_add : {1'b0, t_q[NBITS:1]};
  end

  // Final conditional subtraction; the result is truncated to NBITS, so the
  // subtraction only needs the low NBITS bits.
  always_comb begin
    t_ge_m = (t_q >= {1'b0, m_q});
    t_sub  = t_q[NBITS-1:0] - m_q;
    y_nxt  = t_ge_m ? t_sub : t_q[NBITS-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable_p) begin
          state_nxt = (k_eff == '0) ? FINAL : ITER;
        end
      end
      ITER: begin
        // k_q >= 1 whenever ITER is entered, so k_q - 1 cannot wrap.
        if (cnt_q == (k_q - KW'(1))) begin
          state_nxt = FINAL;
        end
      end
      FINAL: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q        <= '0;
      m_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      y          <= '0;
      done_irq_p <= 1'b0;
    end else begin
      done_irq_p <= (state == FINAL);
      case (state)
        IDLE: begin
          if (enable_p) begin
            t_q   <= {1'b0, a};
            m_q   <= m;
            k_q   <= k_eff;
            cnt_q <= '0;
          end
        end
        ITER: begin
          t_q   <= t_iter;
          cnt_q <= cnt_q + KW'(1);
        end
        FINAL: begin
          y <= y_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_montgomery_redc_serial.sv
// Testbench for montgomery_redc_serial (NBITS = 8): directed timing cases plus
// a randomized back-to-back regression checked through an expected-result queue.
module tb_montgomery_redc_serial;

  localparam int NBITS = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable_p = 1'b0;
  logic [NBITS-1:0] a = '0;
  logic [NBITS-1:0] m = '0;
  logic [10:0]      m_size = '0;
  logic [NBITS-1:0] y;
  logic             done_irq_p;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  montgomery_redc_serial #(.NBITS(NBITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_p   (enable_p),
    .a          (a),
    .m          (m),
    .m_size     (m_size),
    .y          (y),
    .done_irq_p (done_irq_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: the unique y in [0, m) with y * 2^k == a (mod m).
  function automatic int ref_redc(input int av, input int mv, input int kv);
    longint r;
    for (int yy = 0; yy < mv; yy++) begin
      r = (longint'(yy) << kv) % mv;
      if (r == (av % mv)) return yy;
    end
    return -1;
  endfunction

  // Monitor: every completion pulse pops one expected result.
  always @(negedge clk) begin
    int e;
    if (rst_n && done_irq_p) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check(int'(y) == e, "y_result", int'(y), e);
      end
    end
  end

  // Single operation with cycle-accurate checks of busy and done_irq_p.
  task automatic run_dir(input int av, input int mv, input int ms, input int k,
                         input int ye, input string name);
    int done_edge;
    int pulses;
    int busy_bad;
    a = NBITS'(av); m = NBITS'(mv); m_size = 11'(ms); enable_p = 1'b1;
    exp_q.push_back(ye);
    @(posedge clk); #1;
    enable_p  = 1'b0;
    done_edge = -1;
    pulses    = 0;
    busy_bad  = (busy !== 1'b1) ? 1 : 0;
    for (int n = 1; n <= k + 3; n++) begin
      @(posedge clk); #1;
      if (done_irq_p) begin
        pulses++;
        if (done_edge < 0) done_edge = n;
      end
      if (busy !== (n <= k)) busy_bad++;
    end
    check(done_edge == k + 1, {name, "_done_edge"}, done_edge, k + 1);
    check(pulses == 1, {name, "_done_width"}, pulses, 1);
    check(busy_bad == 0, {name, "_busy_profile"}, busy_bad, 0);
  endtask

  initial begin
    int pulses;
    int mv, av, amax, waited, gap;

    // Reset state, held regardless of clock.
    #23;
    check(y == '0, "rst_y", int'(y), 0);
    check(done_irq_p == 1'b0, "rst_done", int'(done_irq_p), 0);
    check(busy == 1'b0, "rst_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_dir(1, 13, 4, 4, 9, "a1");
    run_dir(13, 13, 4, 4, 0, "a13");
    run_dir(0, 13, 4, 4, 0, "a0");
    run_dir(20, 13, 0, 0, 7, "k0");
    run_dir(1, 13, 12, 8, ref_redc(1, 13, 8), "kclamp");

    // Enable during an operation is ignored; input changes do not leak in.
    a = 8'd1; m = 8'd13; m_size = 11'd4; enable_p = 1'b1;
    exp_q.push_back(9);
    @(posedge clk); #1;
    enable_p = 1'b0;
    @(posedge clk); #1;
    enable_p = 1'b1; a = 8'd5;
    @(posedge clk); #1;
    enable_p = 1'b0;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done_irq_p) pulses++;
    end
    check(pulses == 1, "ignored_enable_pulses", pulses, 1);

    // Reset in the middle of an operation aborts it.
    a = 8'd1; m = 8'd13; m_size = 11'd4; enable_p = 1'b1;
    @(posedge clk); #1;
    enable_p = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check(y == '0, "abort_y", int'(y), 0);
    check(busy == 1'b0, "abort_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done_irq_p) pulses++;
    end
    check(pulses == 0, "abort_no_done", pulses, 0);
    check(y == '0, "abort_y_held", int'(y), 0);
    run_dir(1, 13, 4, 4, 9, "after_rst");

    // Randomized regression, mostly back-to-back starts in the done cycle.
    for (int i = 0; i < 1000; i++) begin
      mv   = $urandom_range(1, 127) * 2 + 1;
      amax = (2 * mv - 1 > 255) ? 255 : 2 * mv - 1;
      av   = $urandom_range(0, amax);
      if ($urandom_range(0, 3) == 0) begin
        gap = $urandom_range(1, 3);
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
      a = NBITS'(av); m = NBITS'(mv); m_size = 11'd8; enable_p = 1'b1;
      exp_q.push_back(ref_redc(av, mv, 8));
      @(posedge clk); #1;
      enable_p = 1'b0;
      a = NBITS'($urandom); m = NBITS'($urandom); m_size = 11'($urandom);
      waited = 0;
      while (!done_irq_p && waited < 40) begin
        @(posedge clk); #1;
        waited++;
      end
      check(waited == 9, "rand_latency", waited, 9);
      if (!done_irq_p) break;
    end

    repeat (12) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
